pb_key_scheduler: RTL and testbench

Sequences the 20-button pushbutton bank into a stream of 5-bit key codes, one press at a time. The block synchronizes and debounces `pb[19:0]` and latches every new press into a pending set. It then grants pending presses highest-index-first through a priority-encoder sub-module and buffers the codes in a small FIFO. Codes are drained by a valid/ready consumer (display or UART logic in `top`).

---
 rtl/pb_pkg.sv | 12 +
 rtl/pb_key_scheduler_prio_enc20.sv | 24 ++
 rtl/pb_key_scheduler.sv | 146 ++++++++++++++
 tb/tb_pb_key_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_pkg.sv
// Shared types for the pushbutton key scheduler.
//   NUM_PB      : number of pushbuttons on the board
//   key_code_t  : 5-bit button index (0..NUM_PB-1)
//   pb_vec_t    : one bit per pushbutton
package pb_pkg;

  localparam int NUM_PB = 20;

  typedef logic [4:0]        key_code_t;
  typedef logic [NUM_PB-1:0] pb_vec_t;

endpackage

// File: rtl/pb_key_scheduler_prio_enc20.sv
// prio_enc20: combinational highest-index priority encoder.
// Ports:
//   req  in  20  request vector
//   idx  out 5   index of the highest set bit of req (0 when req is 0)
//   any  out 1   at least one request bit is set
module prio_enc20
  import pb_pkg::*;
(
  input  pb_vec_t   req,
  output key_code_t idx,
  output logic      any
);

  // Ascending scan: the last (highest) set bit wins.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_PB; i++) begin
      if (req[i]) idx = key_code_t'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/pb_key_scheduler.sv
// pb_key_scheduler: synchronizes and debounces 20 pushbuttons, latches new
// presses into a pending set, grants them highest-index-first into a small
// key-code FIFO, and presents the FIFO head to a valid/ready consumer.
// Ports:
//   hz100      in  1   system clock, rising edge
//   reset      in  1   asynchronous active-low reset
//   pb         in  20  raw button levels (1 = pressed), asynchronous
//   key_code   out 5   FIFO head (0 when empty)
//   key_valid  out 1   FIFO non-empty
//   key_ready  in  1   consumer takes the head this cycle
//   pending    out 20  accepted presses not yet queued
//   overflow   out 1   sticky: a press was lost
module pb_key_scheduler
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic      hz100,
  input  logic      reset,
  input  pb_vec_t   pb,
  output key_code_t key_code,
  output logic      key_valid,
  input  logic      key_ready,
  output pb_vec_t   pending,
  output logic      overflow
);

  localparam int              PW       = $clog2(FIFO_DEPTH);
  localparam int              CW       = PW + 1;
  localparam logic [3:0]      CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   DEPTH_C  = CW'(FIFO_DEPTH);

  pb_vec_t         sync1_reg, sync2_reg;
  pb_vec_t         cand_reg, cand_next;
  pb_vec_t         stable_reg, stable_next;
  logic [3:0]      cnt_reg, cnt_next;
  pb_vec_t         pending_reg, pending_next;
  logic            overflow_reg;
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]   count_reg, count_next;
  key_code_t       key_code_reg, head_next;
  logic            key_valid_reg;
  key_code_t       mem [FIFO_DEPTH];

  logic            stable_upd;
  pb_vec_t         rise, grant_mask;
  key_code_t       grant_idx;
  logic            grant_any, push, pop, lost;

  // Debounce: one shared candidate; stable only moves after cand has
  // matched sync2 for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    cand_next   = cand_reg;
    cnt_next    = cnt_reg;
    stable_next = stable_reg;
    stable_upd  = 1'b0;
    if (sync2_reg != cand_reg) begin
      cand_next = sync2_reg;
      cnt_next  = '0;
    end else if (cand_reg != stable_reg) begin
      if (cnt_reg == CNT_LAST) begin
        stable_next = cand_reg;
        cnt_next    = '0;
        stable_upd  = 1'b1;
      end else begin
        cnt_next = cnt_reg + 4'd1;
      end
    end else begin
      cnt_next = '0;
    end
  end

  assign rise = stable_upd ? (cand_reg & ~stable_reg) : '0;

  prio_enc20 u_prio (
    .req (pending_reg),
    .idx (grant_idx),
    .any (grant_any)
  );

  assign pop        = key_valid_reg & key_ready;
  assign push       = grant_any && ((count_reg < DEPTH_C) || pop);
  assign grant_mask = push ? (pb_vec_t'(1) << grant_idx) : '0;

  // Set wins over a same-edge grant clear, so a re-rise of the granted bit
  // stays pending (and a second code will follow).
  assign pending_next = (pending_reg & ~grant_mask) | rise;
  assign lost         = |(rise & pending_reg & ~grant_mask);

  assign count_next  = count_reg + CW'(push) - CW'(pop);
  assign rd_ptr_next = pop ? rd_ptr_reg + PW'(1) : rd_ptr_reg;

  // Next head value: bypass the pushed code when it lands in an empty slot
  // that becomes the head, otherwise read the stored entry.
  always_comb begin
    if (count_next == '0) begin
      head_next = '0;
    end else if (push && ((count_reg - CW'(pop)) == '0)) begin
      head_next = grant_idx;
    end else begin
      head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      sync1_reg     <= '0;
      sync2_reg     <= '0;
      cand_reg      <= '0;
      stable_reg    <= '0;
      cnt_reg       <= '0;
      pending_reg   <= '0;
      overflow_reg  <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      key_code_reg  <= '0;
      key_valid_reg <= 1'b0;
    end else begin
      sync1_reg     <= pb;
      sync2_reg     <= sync1_reg;
      cand_reg      <= cand_next;
      stable_reg    <= stable_next;
      cnt_reg       <= cnt_next;
      pending_reg   <= pending_next;
      overflow_reg  <= overflow_reg | lost;
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      key_code_reg  <= head_next;
      key_valid_reg <= (count_next != '0);
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge hz100) begin
    if (push) mem[wr_ptr_reg] <= grant_idx;
  end

  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign pending   = pending_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_pb_key_scheduler.sv
module tb_pb_key_scheduler;
  import pb_pkg::*;

  logic      hz100 = 1'b0;
  logic      reset = 1'b0;
  pb_vec_t   pb    = '0;
  logic      key_ready;
  key_code_t key_code;
  logic      key_valid;
  pb_vec_t   pending;
  logic      overflow;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   ready_mode   = 0;   // 0: hold low, 1: hold high, 2: random
  logic rand_bit     = 1'b0;
  int   exp_q[$];         // expected key codes in delivery order
  int   exp_head;

  always #5 hz100 = ~hz100;

  assign key_ready = (ready_mode == 2) ? rand_bit : (ready_mode == 1);

  pb_key_scheduler #(.DEBOUNCE_CYCLES(2), .FIFO_DEPTH(4)) dut (
    .hz100     (hz100),
    .reset     (reset),
    .pb        (pb),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .pending   (pending),
    .overflow  (overflow)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge hz100);
      #1;
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check_val(tag, exp_q.size(), 0);
  endtask

  // Consumer side scoreboard: every accepted code must be the next expected.
  always @(negedge hz100) begin
    if (reset && key_valid && key_ready) begin
      if (exp_q.size() == 0) begin
        check_val("pop_unexpected", key_code, 32'hDEAD);
      end else begin
        exp_head = exp_q.pop_front();
        check_val("pop_code", key_code, exp_head);
      end
      $display("[TB] pop code %0d at %0t", key_code, $time);
    end
  end

  initial begin
    forever begin
      @(posedge hz100);
      #1;
      rand_bit = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    pb_vec_t mask, glitch;

    // Reset state
    tick(3);
    check_val("rst_key_code", key_code, 0);
    check_val("rst_key_valid", key_valid, 0);
    check_val("rst_pending", pending, 0);
    check_val("rst_overflow", overflow, 0);
    reset = 1'b1;
    tick(3);

    // Single press: pending after edge 5, key_valid after edge 6
    pb[7] = 1'b1;
    tick(5);
    check_val("single_pending_e5", pending, 32'h80);
    check_val("single_valid_e5", key_valid, 0);
    tick(1);
    check_val("single_valid_e6", key_valid, 1);
    check_val("single_code_e6", key_code, 7);
    check_val("single_pending_e6", pending, 0);
    exp_q.push_back(7);
    ready_mode = 1;
    tick(1);
    ready_mode = 0;
    check_val("single_valid_after_pop", key_valid, 0);
    check_val("single_drained", exp_q.size(), 0);
    $display("[TB] single press done");
    pb = '0;
    tick(12);

    // Bounce 1,0,1 then hold: one code 3
    ready_mode = 1;
    exp_q.push_back(3);
    pb[3] = 1'b1; tick(1);
    pb[3] = 1'b0; tick(1);
    pb[3] = 1'b1; tick(20);
    wait_drain("bounce_drain", 40);
    check_val("bounce_valid", key_valid, 0);
    pb = '0;
    tick(12);
    // One-cycle pulse: nothing
    pb[3] = 1'b1; tick(1);
    pb[3] = 1'b0; tick(20);
    check_val("pulse_pending", pending, 0);
    check_val("pulse_valid", key_valid, 0);
    $display("[TB] bounce and pulse done");

    // Simultaneous 19, 12, 0 with ready high: three back-to-back codes
    exp_q.push_back(19);
    exp_q.push_back(12);
    exp_q.push_back(0);
    pb[19] = 1'b1; pb[12] = 1'b1; pb[0] = 1'b1;
    k = 0;
    while (!key_valid && k < 20) begin
      tick(1);
      k++;
    end
    for (int i = 0; i < 3; i++) begin
      check_val("simul_valid_run", key_valid, 1);
      tick(1);
    end
    check_val("simul_valid_end", key_valid, 0);
    wait_drain("simul_drain", 5);
    $display("[TB] simultaneous presses done");
    pb = '0;
    tick(12);

    // Backpressure: six separate presses, FIFO holds four
    ready_mode = 0;
    for (int i = 1; i <= 6; i++) begin
      pb[i] = 1'b1;
      tick(8);
    end
    tick(10);
    check_val("bp_valid", key_valid, 1);
    check_val("bp_pending", pending, 32'h60);
    check_val("bp_overflow", overflow, 0);
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    exp_q.push_back(4); exp_q.push_back(6); exp_q.push_back(5);
    ready_mode = 1;
    wait_drain("bp_drain", 40);
    tick(2);
    check_val("bp_valid_end", key_valid, 0);
    $display("[TB] backpressure done");
    ready_mode = 0;
    pb = '0;
    tick(12);

    // Overflow: FIFO full, press 9, release, press 9 again
    for (int i = 1; i <= 4; i++) begin
      pb[i] = 1'b1;
      tick(8);
    end
    tick(6);
    pb[9] = 1'b1; tick(10);
    check_val("ovf_pending_first", pending, 32'h200);
    check_val("ovf_before", overflow, 0);
    pb[9] = 1'b0; tick(10);
    pb[9] = 1'b1; tick(10);
    check_val("ovf_set", overflow, 1);
    check_val("ovf_pending", pending, 32'h200);
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    exp_q.push_back(4); exp_q.push_back(9);
    ready_mode = 1;
    wait_drain("ovf_drain", 40);
    tick(5);
    check_val("ovf_valid_end", key_valid, 0);
    check_val("ovf_sticky", overflow, 1);
    $display("[TB] overflow done");
    ready_mode = 0;
    pb = '0;
    tick(12);

    // Reset mid-operation
    for (int i = 1; i <= 5; i++) begin
      pb[i] = 1'b1;
      tick(8);
    end
    tick(10);
    check_val("rstmid_pre_valid", key_valid, 1);
    check_val("rstmid_pre_pending", pending, 32'h20);
    pb = '0;
    #3;
    reset = 1'b0;
    #1;
    check_val("rstmid_key_code", key_code, 0);
    check_val("rstmid_key_valid", key_valid, 0);
    check_val("rstmid_pending", pending, 0);
    check_val("rstmid_overflow", overflow, 0);
    exp_q.delete();
    tick(3);
    reset = 1'b1;
    ready_mode = 1;
    tick(30);
    check_val("rstmid_post_valid", key_valid, 0);
    check_val("rstmid_post_pending", pending, 0);
    $display("[TB] reset mid-operation done");

    // Randomized: each event is a set of buttons rising together, optionally
    // preceded by a one-cycle glitch; codes must arrive highest index first.
    for (int ev = 0; ev < 30; ev++) begin
      mask = '0;
      for (int b = 0; b < int'($urandom_range(1, 3)); b++)
        mask[$urandom_range(0, NUM_PB - 1)] = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        glitch = pb_vec_t'($urandom) & 20'hFFFFF;
        pb = glitch;
        tick(1);
        pb = '0;
        tick(6);
      end
      for (int i = NUM_PB - 1; i >= 0; i--)
        if (mask[i]) exp_q.push_back(i);
      ready_mode = 2;
      pb = mask;
      tick(8);
      wait_drain("rand_drain", 200);
      $display("[TB] random event %0d mask 0x%05h done", ev, mask);
      pb = '0;
      tick(12);
    end
    tick(4);
    check_val("final_pending", pending, 0);
    check_val("final_overflow", overflow, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
